// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// The priority encoder lives here so every user agrees on the action order.
package pc_seq_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_OFF_W      = 8;
  localparam int DEF_RAS_DEPTH  = 4;
  localparam int DEF_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_INC
  } next_sel_t;

  // Exactly one action per cycle: stall > ret > call > jump > branch > increment.
  function automatic next_sel_t encode_sel(input logic stall,
                                           input logic ret,
                                           input logic call,
                                           input logic jump,
                                           input logic branch);
    if (stall)       return SEL_HOLD;
    else if (ret)    return SEL_RET;
    else if (call)   return SEL_CALL;
    else if (jump)   return SEL_JUMP;
    else if (branch) return SEL_BRANCH;
    else             return SEL_INC;
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Control-decoder <-> sequencer bundle: requests in, fetch address and RAS status out.
interface pc_seq_unit_if
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OFF_W  = DEF_OFF_W
) ();

  logic              stall;
  logic              branch;
  logic [OFF_W-1:0]  offset;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] address;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, branch, offset, jump, call, ret, target,
    input  address, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch, offset, jump, call, ret, target,
    output address, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// push and pop are expected to be mutually exclusive; push wins if both are seen.
module pc_ras #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  push_ptr;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(RAS_DEPTH));
  assign overflow  = push && full;
  assign underflow = pop && !push && empty;
  assign top       = mem[top_ptr];
  // When full, the slot after the top is the oldest entry, so it is the one overwritten.
  assign push_ptr  = top_ptr + PTR_W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= push_ptr;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // NOTE: storage has no reset; entries are only readable after a push, so reset is wasted logic.
  always_ff @(negedge CLK) begin
    if (push) mem[push_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, relative branch, jump, call/return via RAS, stall.
// All state updates on the falling edge of CLK; RESET is asynchronous, active-high.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int OFF_W      = DEF_OFF_W,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter int RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic         CLK,
  input  logic         RESET,
  pc_seq_unit_if.slave bus
);

  next_sel_t         sel;
  logic [ADDR_W-1:0] address_q;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_branch;
  logic [OFF_W-1:0]  offset_w;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;
  logic              ras_err_q;
  logic              push;
  logic              pop;

  assign sel      = encode_sel(bus.stall, bus.ret, bus.call, bus.jump, bus.branch);
  assign push     = (sel == SEL_CALL);
  assign pop      = (sel == SEL_RET);
  assign offset_w = bus.offset;

  // Widening a signed value sign-extends; all sums then wrap modulo 2^ADDR_W.
  assign off_ext     = ADDR_W'($signed(offset_w));
  assign addr_inc    = address_q + ADDR_W'(1);
  assign addr_branch = addr_inc + off_ext;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .pop      (pop),
    .push_data(addr_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );

  // NOTE: default assignment first so no path through the case leaves addr_next unassigned (no latch).
  always_comb begin
    addr_next = address_q;
    unique case (sel)
      SEL_HOLD:   addr_next = address_q;
      SEL_RET:    addr_next = ras_empty ? addr_inc : ras_top;
      SEL_CALL:   addr_next = bus.target;
      SEL_JUMP:   addr_next = bus.target;
      SEL_BRANCH: addr_next = addr_branch;
      SEL_INC:    addr_next = addr_inc;
      default:    addr_next = address_q;
    endcase
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      address_q <= ADDR_W'(RESET_ADDR);
      ras_err_q <= 1'b0;
    end else begin
      address_q <= addr_next;
      if (ras_overflow || ras_underflow) ras_err_q <= 1'b1;
    end
  end

  assign bus.address   = address_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = ras_err_q;

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer and successor to the single-mode 8-bit PC.
- Generates the instruction-fetch address each cycle. Supports sequential increment, PC-relative branch, absolute jump, call/return through an internal return-address stack (RAS), and pipeline stall.
- Sits between the control decoder and instruction memory; all state updates on the falling edge of CLK.

Parameters:
- ADDR_W, 8, width of the fetch address in bits.
- OFF_W, 8, width of the signed branch offset; must be <= ADDR_W.
- RAS_DEPTH, 4, number of return-address stack entries; power of two, >= 2.
- RESET_ADDR, 0, address loaded on reset.

Ports:
- CLK  input  1  clock; state changes on the falling edge.
- RESET  input  1  reset, asynchronous, active-high.
- stall  input  1  hold address and RAS unchanged this cycle.
- branch  input  1  take a PC-relative branch.
- offset  input  OFF_W  two's-complement branch offset.
- jump  input  1  absolute jump to target.
- call  input  1  push return address, then jump to target.
- ret  input  1  pop return address into PC.
- target  input  ADDR_W  absolute destination for jump and call.
- address  output  ADDR_W  current fetch address (registered).
- ras_empty  output  1  RAS holds zero entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky: push-when-full or pop-when-empty has occurred.

Behaviour:
- Reset (async, any time, including mid-operation): address=RESET_ADDR, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. RAS entry contents are don't-care.
- Each falling edge, with RESET low, exactly one action is taken, in priority order: stall > ret > call > jump > branch > increment.
- stall: address, RAS and ras_err are all unchanged.
- ret with RAS non-empty: address = top entry; count decrements.
- ret with RAS empty: address = address+1; ras_err is set; count stays 0.
- call: pushes address+1 and sets address = target.
  - If the RAS is full, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_err is set.
- jump: address = target; RAS unchanged.
- branch: address = address + 1 + sign_extend(offset) to ADDR_W.
- increment (no control input asserted): address = address + 1.
- All address arithmetic is modulo 2^ADDR_W. Wrap-around is silent: max+1 -> 0, and negative results wrap.
- Lower-priority requests asserted in the same cycle are ignored, not queued. Example: call+ret together -> ret only.
- ras_empty and ras_full are combinational from the count and are valid in the same cycle the count changes.
- ras_err clears only on RESET.
- Latency: the new address is visible immediately after the falling edge in which its request is sampled; no bubbles are inserted.

Decomposition:
- Shared package pc_seq_pkg holds:
  - enum next_sel_t {SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_INC}, produced by a priority encoder.
  - Default parameter constants.
- One sub-module, pc_ras:
  - Circular stack with push/pop, parameterised by ADDR_W and RAS_DEPTH.
  - Outputs: top, empty, full, overflow/underflow pulses.
- pc_seq_unit owns the select logic, the address register and the sticky error flag.

Test Plan:
- Reset then 3 idle cycles -> address 0,1,2,3. Assert RESET asynchronously mid-cycle -> address=0 immediately, ras_empty=1.
- address=10, branch, offset=8'hFB (-5) -> address=6. Address=8'hFE, branch, offset=+3 -> address=2 (wrap).
- address=20, call, target=50 -> 50, RAS top=21. Increment 2 cycles -> 52. ret -> 21, ras_empty=1.
- RAS_DEPTH=4: 5 nested calls -> ras_full=1 and ras_err=1 after the 5th. 4 rets return the 4 newest addresses in LIFO order. A 5th ret -> address+1, ras_empty=1, ras_err remains 1.
- stall held 3 cycles with call+branch asserted -> address and RAS frozen. Release with ret+jump asserted -> ret taken, jump ignored.
- ret on empty RAS at address=7 -> address=8, ras_err=1. ras_err stays 1 through 10 normal cycles and clears only on RESET.
